fft_frame_ctrl: RTL and testbench
=================================

Name: fft_frame_ctrl

Overview:
- Sequences one FFT frame end to end: capture of serial input words into the 32-word deserializer shift register, start of the FFT core, and unload of results.
- Frame = N_POINTS real words followed by N_POINTS imaginary words.
- Sits between the sample source, the deserializer, the FFT core and the output serializer.
- Owns all frame-level handshakes so the datapath blocks need no counters of their own.

Parameters:
- N_POINTS, 16, complex points per frame; words per frame WORDS = 2*N_POINTS.
- CNT_W, $clog2(2*N_POINTS), width of word indices.
- TIMEOUT_CYC, 1024, COMPUTE watchdog limit; used only with FFT_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present on the deserializer datain.
- in_ready  out  1  controller accepts input; high in IDLE and CAPTURE.
- cap_shift  out  1  deserializer shift enable = in_valid & in_ready (combinational).
- cap_count  out  CNT_W  words accepted so far in the current frame.
- fft_start  out  1  one-cycle registered pulse; deserializer outputs are stable.
- fft_done  in  1  FFT core result-ready pulse/level.
- out_index  out  CNT_W  result word select; 0..N_POINTS-1 real, N_POINTS..WORDS-1 imaginary.
- out_valid  out  1  out_index is valid.
- out_ready  in  1  downstream accepts the current word.
- out_last  out  1  out_valid & (out_index == WORDS-1).
- busy  out  1  state != IDLE.
- overrun  out  1  sticky; set by in_valid while in_ready is low.
- timeout_err  out  1  sticky watchdog flag; constant 0 without FFT_TIMEOUT_EN.

Behaviour:
- Reset (synchronous, active-high; dominates all other events, including mid-frame):
  - State goes to IDLE.
  - cap_count, out_index = 0.
  - fft_start, out_valid, overrun, timeout_err = 0.
  - Any partial frame is discarded.
- State register: IDLE, CAPTURE, START, COMPUTE, UNLOAD.
- Accept = in_valid & in_ready.
- IDLE:
  - in_ready = 1.
  - On accept: cap_count <= 1, go to CAPTURE.
  - in_valid = 0: stay in IDLE.
- CAPTURE:
  - in_ready = 1.
  - Each accept increments cap_count.
  - Accept while cap_count == WORDS-1: cap_count <= 0, go to START.
  - Gaps in in_valid are allowed; the count holds.
- START:
  - fft_start = 1 for exactly this one cycle.
  - fft_start asserts on the cycle after word WORDS-1 was shifted, so latency is 1 clock.
  - Unconditionally go to COMPUTE.
- COMPUTE:
  - in_ready = 0.
  - fft_done is sampled only in this state; sampled high -> out_index <= 0, go to UNLOAD.
  - fft_done in any other state is ignored.
- UNLOAD:
  - out_valid = 1.
  - On out_ready: out_index increments.
  - out_ready high at out_index == WORDS-1: out_index <= 0, go to IDLE.
  - out_ready low: out_index and out_valid hold (no skip, no drop).
- Back-to-back frames: IDLE accepts the next word on the cycle after out_last completes. There is no dead cycle beyond the state transition.
- overrun:
  - Set when in_valid = 1 while state is START, COMPUTE or UNLOAD.
  - The word is not shifted (cap_shift = 0).
  - Cleared only by reset.
- Counters wrap only through the explicit clears above; they never increment past WORDS-1.

Optional Feature:
- Macro: FFT_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to COMPUTE and increments each COMPUTE cycle.
  - Count reaches TIMEOUT_CYC-1 without fft_done: go to IDLE, set timeout_err (sticky), no UNLOAD.
  - fft_done on the same cycle as expiry wins and goes to UNLOAD.
- Not defined: no watchdog logic; timeout_err tied 0; COMPUTE waits indefinitely.

Decomposition:
- Shared package fft_ctrl_pkg:
  - state enum type fft_ctrl_state_t.
  - Default N_POINTS, WORDS and CNT_W constants.
  - Default TIMEOUT_CYC.
- Sub-module fft_word_counter:
  - Generic up-counter with en, clr and terminal flag (== LIMIT-1).
  - Instantiated twice: capture count and out_index.

Test Plan:
- Reset, then 32 consecutive in_valid words 1..32 -> cap_shift high 32 cycles; fft_start high exactly once, one cycle after word 32; in_ready low from that cycle.
- Capture with in_valid low for 3 cycles after word 10 -> cap_count holds at 10; frame completes after 32 accepted words; no extra fft_start.
- fft_done 5 cycles after fft_start; out_ready toggles 1,0,1,... -> out_index steps 0..31 only on ready cycles; out_last only at index 31; back to IDLE next cycle.
- in_valid during COMPUTE -> overrun = 1 and stays 1; cap_shift = 0; reset clears overrun.
- Reset asserted at cap_count = 20 -> next cycle IDLE, cap_count = 0; following full frame behaves normally.
- FFT_TIMEOUT_EN, TIMEOUT_CYC = 8, fft_done never asserted -> IDLE after 8 COMPUTE cycles; timeout_err = 1; out_valid never asserted.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared types and default sizing for the FFT frame controller.
package fft_ctrl_pkg;

  localparam int N_POINTS_DEF    = 16;
  localparam int WORDS_DEF       = 2 * N_POINTS_DEF;
  localparam int CNT_W_DEF       = $clog2(WORDS_DEF);
  localparam int TIMEOUT_CYC_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_START   = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_UNLOAD  = 3'd4
  } fft_ctrl_state_t;

endpackage

// File: rtl/fft_word_counter.sv
// Up-counter 0..LIMIT-1 with enable, synchronous clear and terminal flag.
module fft_word_counter #(
  parameter int LIMIT = 32,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         term
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign term  = (count_q == W'(LIMIT - 1));
  assign count = count_q;

  // Next count: clear wins, terminal increments fold back to zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {W{1'b0}};
    end else if (en) begin
      if (term) begin
        count_d = {W{1'b0}};
      end else begin
        count_d = count_q + W'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: capture -> FFT start -> compute -> unload.
// Optional COMPUTE watchdog enabled by defining FFT_TIMEOUT_EN.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int N_POINTS = N_POINTS_DEF,
  parameter int CNT_W    = $clog2(2 * N_POINTS)
`ifdef FFT_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             cap_shift,
  output logic [CNT_W-1:0] cap_count,
  output logic             fft_start,
  input  logic             fft_done,
  output logic [CNT_W-1:0] out_index,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err
);

  localparam int WORDS = 2 * N_POINTS;

  fft_ctrl_state_t state_q, state_d;
  logic in_ready_q, in_ready_d;
  logic fft_start_q, fft_start_d;
  logic out_valid_q, out_valid_d;
  logic busy_q, busy_d;
  logic overrun_q, overrun_d;
  logic accept_s, cap_term_s, out_step_s, out_term_s, out_clr_s;
  logic wd_term_s, wd_expire_s;

  assign accept_s    = in_valid & in_ready_q;
  assign out_step_s  = out_valid_q & out_ready;
  assign out_clr_s   = (state_q == ST_COMPUTE) & fft_done;
  assign wd_expire_s = (state_q == ST_COMPUTE) & ~fft_done & wd_term_s;

  fft_word_counter #(.LIMIT(WORDS), .W(CNT_W)) u_cap_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (accept_s),
    .clr   (1'b0),
    .count (cap_count),
    .term  (cap_term_s)
  );

  fft_word_counter #(.LIMIT(WORDS), .W(CNT_W)) u_out_idx (
    .clk   (clk),
    .reset (reset),
    .en    (out_step_s),
    .clr   (out_clr_s),
    .count (out_index),
    .term  (out_term_s)
  );

  // Next-state logic; outputs are registered from the next state so they align with it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept_s) state_d = ST_CAPTURE; else state_d = ST_IDLE;
      ST_CAPTURE: if (accept_s && cap_term_s) state_d = ST_START; else state_d = ST_CAPTURE;
      ST_START:   state_d = ST_COMPUTE;
      ST_COMPUTE: begin
        if (fft_done) begin
          state_d = ST_UNLOAD;
        end else if (wd_expire_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_COMPUTE;
        end
      end
      ST_UNLOAD:  if (out_step_s && out_term_s) state_d = ST_IDLE; else state_d = ST_UNLOAD;
      default:    state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_CAPTURE);
    fft_start_d = (state_d == ST_START);
    out_valid_d = (state_d == ST_UNLOAD);
    busy_d      = (state_d != ST_IDLE);
    overrun_d   = overrun_q | (in_valid & ~in_ready_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      fft_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      fft_start_q <= fft_start_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef FFT_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;

  assign wd_term_s = (wd_q == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog counts only while staying in COMPUTE, so it reads zero on entry.
  always_comb begin
    if ((state_q == ST_COMPUTE) && (state_d == ST_COMPUTE)) begin
      wd_d = wd_q + WD_W'(1);
    end else begin
      wd_d = {WD_W{1'b0}};
    end
    timeout_d = timeout_q | wd_expire_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q      <= {WD_W{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign wd_term_s   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign cap_shift = accept_s;
  assign fft_start = fft_start_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q & out_term_s;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: vector table, directed sequences, random vs. frame model.
module tb_fft_frame_ctrl;

  localparam int NP    = 16;
  localparam int WORDS = 2 * NP;
  localparam int CW    = 5;
`ifdef FFT_TIMEOUT_EN
  localparam int TCYC  = 8;
`endif

  localparam int P_COLLECT = 0;
  localparam int P_KICK    = 1;
  localparam int P_WAIT    = 2;
  localparam int P_DRAIN   = 3;

  logic          clk = 1'b0;
  logic          reset, in_valid, fft_done, out_ready;
  logic          in_ready, cap_shift, fft_start, out_valid, out_last, busy, overrun, timeout_err;
  logic [CW-1:0] cap_count, out_index;

  always #5 clk = ~clk;

  fft_frame_ctrl #(
    .N_POINTS (NP),
    .CNT_W    (CW)
`ifdef FFT_TIMEOUT_EN
    , .TIMEOUT_CYC (TCYC)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cap_shift   (cap_shift),
    .cap_count   (cap_count),
    .fft_start   (fft_start),
    .fft_done    (fft_done),
    .out_index   (out_index),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  int checks = 0;
  int errors = 0;

  // Frame model: phase of the frame, words taken, results sent, watchdog cycles.
  int m_phase, m_cnt, m_idx, m_wd;
  bit m_ovr, m_tmo;
  logic d_rst, d_iv, d_done, d_ordy;

  typedef struct {
    logic          rst;
    logic          iv;
    logic          exp_rdy;
    logic          exp_shift;
    logic [CW-1:0] exp_cnt;
    logic          exp_busy;
    logic          exp_ovr;
  } vec_t;
  vec_t tv[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    bit ready;
    if (d_rst) begin
      m_phase = P_COLLECT; m_cnt = 0; m_idx = 0; m_wd = 0; m_ovr = 0; m_tmo = 0;
    end else begin
      ready = (m_phase == P_COLLECT);
      if (d_iv && !ready) m_ovr = 1;
      case (m_phase)
        P_COLLECT: if (d_iv) begin
          m_cnt++;
          if (m_cnt == WORDS) begin m_cnt = 0; m_phase = P_KICK; end
        end
        P_KICK: begin m_phase = P_WAIT; m_wd = 0; end
        P_WAIT: begin
          if (d_done) begin m_phase = P_DRAIN; m_idx = 0; end
`ifdef FFT_TIMEOUT_EN
          else if (m_wd == TCYC - 1) begin m_phase = P_COLLECT; m_tmo = 1; end
`endif
          else m_wd++;
        end
        default: if (d_ordy) begin
          m_idx++;
          if (m_idx == WORDS) begin m_idx = 0; m_phase = P_COLLECT; end
        end
      endcase
    end
  endtask

  task automatic compare_model();
    bit rdy;
    rdy = (m_phase == P_COLLECT);
    chk("in_ready",    in_ready,    rdy);
    chk("cap_shift",   cap_shift,   d_iv && rdy);
    chk("cap_count",   cap_count,   m_cnt);
    chk("fft_start",   fft_start,   m_phase == P_KICK);
    chk("out_valid",   out_valid,   m_phase == P_DRAIN);
    chk("out_index",   out_index,   m_idx);
    chk("out_last",    out_last,    (m_phase == P_DRAIN) && (m_idx == WORDS - 1));
    chk("busy",        busy,        !((m_phase == P_COLLECT) && (m_cnt == 0)));
    chk("overrun",     overrun,     m_ovr);
    chk("timeout_err", timeout_err, m_tmo);
  endtask

  task automatic drive(input logic r, input logic iv, input logic dn, input logic ordy);
    @(negedge clk);
    d_rst = r; d_iv = iv; d_done = dn; d_ordy = ordy;
    reset = r; in_valid = iv; fft_done = dn; out_ready = ordy;
    #1;
    compare_model();
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
  endtask

  task automatic cyc(input logic r, input logic iv, input logic dn, input logic ordy);
    drive(r, iv, dn, ordy);
    adv();
  endtask

  initial begin
    int starts, compute_cyc, valid_cyc;
    tv[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0};
    tv[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0};
    tv[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0};
    tv[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0};
    tv[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0};
    tv[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0};
    tv[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; fft_done = 1'b0; out_ready = 1'b0;
    d_rst = 1'b1; d_iv = 1'b0; d_done = 1'b0; d_ordy = 1'b0;
    repeat (2) @(posedge clk);
    model_step();

    // Table: reset state, first accepts, gap hold, mid-capture reset.
    for (int i = 0; i < 7; i++) begin
      drive(tv[i].rst, tv[i].iv, 1'b0, 1'b0);
      chk("tv_in_ready", in_ready,  tv[i].exp_rdy);
      chk("tv_shift",    cap_shift, tv[i].exp_shift);
      chk("tv_count",    cap_count, tv[i].exp_cnt);
      chk("tv_busy",     busy,      tv[i].exp_busy);
      chk("tv_overrun",  overrun,   tv[i].exp_ovr);
      adv();
    end

    // Full frame, start latency, done after 5 cycles, toggling out_ready unload.
    for (int i = 0; i < WORDS; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      chk("seq1_shift", cap_shift, 1'b1);
      adv();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("seq1_start_pulse", fft_start, 1'b1);
    chk("seq1_ready_low", in_ready, 1'b0);
    adv();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("seq1_start_once", fft_start, 1'b0);
    adv();
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2 * WORDS - 1; k++) begin
      drive(1'b0, 1'b0, 1'b0, (k % 2) == 0);
      if ((k % 2) == 0) begin
        chk("seq1_index", out_index, k / 2);
        chk("seq1_last", out_last, (k / 2) == WORDS - 1);
      end
      adv();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("seq1_idle_valid", out_valid, 1'b0);
    chk("seq1_idle_busy", busy, 1'b0);
    adv();

    // Gap after word 10, then overrun during COMPUTE, then reset clears it.
    starts = 0;
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("seq2_hold10", cap_count, 10);
      adv();
    end
    for (int i = 0; i < WORDS - 10; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      if (fft_start === 1'b1) starts++;
      adv();
    end
    chk("seq2_no_early_start", starts, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("seq2_no_shift", cap_shift, 1'b0);
    adv();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("seq2_overrun", overrun, 1'b1);
    adv();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < WORDS; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("seq2_overrun_sticky", overrun, 1'b1);
    adv();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("seq2_overrun_clear", overrun, 1'b0);
    adv();

    // Reset at cap_count 20, then a normal frame.
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("seq3_count_clr", cap_count, 0);
    chk("seq3_idle", busy, 1'b0);
    adv();
    starts = 0;
    for (int i = 0; i < WORDS + 3; i++) begin
      drive(1'b0, i < WORDS, 1'b0, 1'b0);
      if (fft_start === 1'b1) starts++;
      adv();
    end
    chk("seq3_one_start", starts, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < WORDS; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Watchdog: fft_done never arrives.
    for (int i = 0; i < WORDS + 1; i++) cyc(1'b0, i < WORDS, 1'b0, 1'b0);
    compute_cyc = 0; valid_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      if (busy === 1'b1 && in_ready === 1'b0) compute_cyc++;
      if (out_valid === 1'b1) valid_cyc++;
      adv();
    end
    chk("seq4_no_valid", valid_cyc, 0);
`ifdef FFT_TIMEOUT_EN
    chk("seq4_compute_cycles", compute_cyc, TCYC);
    chk("seq4_timeout_err", timeout_err, 1'b1);
`else
    chk("seq4_compute_cycles", compute_cyc, 20);
    chk("seq4_timeout_err", timeout_err, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < WORDS; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
`endif
    cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // Random traffic checked every cycle against the frame model.
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(199, 0) == 0,
          $urandom_range(9, 0) < 6,
          $urandom_range(11, 0) == 0,
          $urandom_range(3, 0) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
